button_event_ctrl: RTL

//  Sits behind the debounce block: takes its PORT_WIDTH debounced button levels and turns them into

---
 rtl/btn_evt_pkg.sv | 24 ++
 rtl/btn_hold_tracker.sv | 105 ++++++++++
 rtl/button_event_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_evt_pkg
// Brief  : Event codes and hold-tracker state encoding shared by the button
//          event controller, its consumers and its testbench.
// Rev    : 1.0  initial release
// ============================================================================
package btn_evt_pkg;

  // Event codes carried on evt_code
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  // Per-button tracker states
  typedef enum logic [1:0] {
    TRK_IDLE = 2'd0,
    TRK_HELD = 2'd1,
    TRK_RPT  = 2'd2
  } trk_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_hold_tracker.sv
`default_nettype none
// ============================================================================
// Module : btn_hold_tracker
// Brief  : Edge detector, hold timer and PRESS/RELEASE/LONG/REPEAT state
//          machine for a single debounced button. emit_o/code_o are
//          combinational and valid for the current cycle only.
// Rev    : 1.0  initial release
// ============================================================================
module btn_hold_tracker
  import btn_evt_pkg::*;
#(
  parameter int LONG_CLOCKS   = 1000000,
  parameter int REPEAT_CLOCKS = 200000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  output logic       emit_o,
  output logic [1:0] code_o
);

  localparam int MAX_CLOCKS = (LONG_CLOCKS > REPEAT_CLOCKS) ? LONG_CLOCKS : REPEAT_CLOCKS;
  localparam int TW         = $clog2(MAX_CLOCKS + 1);

  localparam logic [TW-1:0] LONG_T = TW'(LONG_CLOCKS);
  localparam logic [TW-1:0] RPT_T  = TW'(REPEAT_CLOCKS);
  localparam logic [TW-1:0] ONE_T  = TW'(1);
  localparam logic [TW-1:0] SAT_T  = {TW{1'b1}};

  trk_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          prev_q;
  logic          rise_w, fall_w;

  assign rise_w = btn_i & ~prev_q;
  assign fall_w = ~btn_i & prev_q;

  // State, timer and previous-level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRK_IDLE;
      timer_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prev_q  <= btn_i;
    end
  end

  // Next state, timer update and event emission; a fall beats a due LONG/REPEAT
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    emit_o  = 1'b0;
    code_o  = EVT_PRESS;
    case (state_q)
      TRK_IDLE: begin
        if (rise_w) begin
          emit_o  = 1'b1;
          code_o  = EVT_PRESS;
          state_d = TRK_HELD;
          timer_d = ONE_T;
        end
      end
      TRK_HELD: begin
        if (fall_w) begin
          emit_o  = 1'b1;
          code_o  = EVT_RELEASE;
          state_d = TRK_IDLE;
          timer_d = '0;
        end else if (timer_q == LONG_T) begin
          emit_o  = 1'b1;
          code_o  = EVT_LONG;
          state_d = TRK_RPT;
          timer_d = ONE_T;
        end else begin
          timer_d = timer_q + ONE_T;
        end
      end
      TRK_RPT: begin
        if (fall_w) begin
          emit_o  = 1'b1;
          code_o  = EVT_RELEASE;
          state_d = TRK_IDLE;
          timer_d = '0;
        end else if (REPEAT_EN && (timer_q == RPT_T)) begin
          emit_o  = 1'b1;
          code_o  = EVT_REPEAT;
          timer_d = ONE_T;
        end else if (timer_q != SAT_T) begin
          // Without repeats the timer just runs up and parks at all-ones
          timer_d = timer_q + ONE_T;
        end
      end
      default: begin
        state_d = TRK_IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module : button_event_ctrl
// Brief  : Per-button event generation, one pending slot per button, a
//          round-robin arbiter and a shared event FIFO popped over a
//          valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int PORT_WIDTH    = 4,
  parameter int LONG_CLOCKS   = 1000000,
  parameter int REPEAT_CLOCKS = 200000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int FIFO_DEPTH    = 8,
  localparam int IDW          = (PORT_WIDTH > 1) ? $clog2(PORT_WIDTH) : 1,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_WIDTH-1:0] btn_db,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IDW-1:0]        evt_id,
  output logic [1:0]            evt_code,
  output logic                  evt_ovf,
  output logic [LW-1:0]         fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Tracker outputs
  logic [PORT_WIDTH-1:0] emit_w;
  logic [1:0]            emit_code_w [PORT_WIDTH];

  // Pending slots
  logic [PORT_WIDTH-1:0] pend_v_q, pend_v_d;
  logic [1:0]            pend_code_q [PORT_WIDTH];
  logic [1:0]            pend_code_d [PORT_WIDTH];
  logic                  ovf_q, ovf_d;

  // Arbiter
  logic [IDW-1:0]        rr_q, rr_d;
  logic                  req_found_w;
  logic [IDW-1:0]        req_idx_w;
  logic                  gnt_v_w;
  logic [PORT_WIDTH-1:0] gnt_oh_w;

  // FIFO
  logic [IDW-1:0]        mem_id_q   [FIFO_DEPTH];
  logic [1:0]            mem_code_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         cnt_q;
  logic                  full_w, pop_w, push_w, can_push_w;

  genvar g;
  generate
    for (g = 0; g < PORT_WIDTH; g++) begin : g_trk
      btn_hold_tracker #(
        .LONG_CLOCKS  (LONG_CLOCKS),
        .REPEAT_CLOCKS(REPEAT_CLOCKS),
        .REPEAT_EN    (REPEAT_EN)
      ) u_trk (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (btn_db[g]),
        .emit_o(emit_w[g]),
        .code_o(emit_code_w[g])
      );
    end
  endgenerate

  // Index 'offs' places after 'base', wrapping at PORT_WIDTH
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
    int j;
    j = int'(base) + offs;
    if (j >= PORT_WIDTH) j = j - PORT_WIDTH;
    return IDW'(j);
  endfunction

  assign full_w     = (cnt_q == LW'(FIFO_DEPTH));
  assign pop_w      = (cnt_q != '0) && evt_ready;
  assign can_push_w = !full_w || pop_w;
  assign gnt_v_w    = req_found_w && can_push_w;
  assign push_w     = gnt_v_w;

  // First occupied slot at or after the round-robin pointer
  always_comb begin
    req_found_w = 1'b0;
    req_idx_w   = '0;
    for (int k = 0; k < PORT_WIDTH; k++) begin
      if (!req_found_w && pend_v_q[rr_idx(rr_q, k)]) begin
        req_found_w = 1'b1;
        req_idx_w   = rr_idx(rr_q, k);
      end
    end
  end

  // One-hot grant and pointer advance past the winner
  always_comb begin
    gnt_oh_w = '0;
    rr_d     = rr_q;
    if (gnt_v_w) begin
      gnt_oh_w[req_idx_w] = 1'b1;
      rr_d = (req_idx_w == IDW'(PORT_WIDTH - 1)) ? '0 : req_idx_w + IDW'(1);
    end
  end

  // Slot update: a slot being granted may reload in the same cycle; otherwise an occupied slot drops
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < PORT_WIDTH; i++) begin
      pend_v_d[i]    = pend_v_q[i];
      pend_code_d[i] = pend_code_q[i];
      if (emit_w[i]) begin
        if (pend_v_q[i] && !gnt_oh_w[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_v_d[i]    = 1'b1;
          pend_code_d[i] = emit_code_w[i];
        end
      end else if (gnt_oh_w[i]) begin
        pend_v_d[i] = 1'b0;
      end
    end
  end

  // Pending slots, overflow flag and arbiter pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q <= '0;
      ovf_q    <= 1'b0;
      rr_q     <= '0;
      for (int i = 0; i < PORT_WIDTH; i++) pend_code_q[i] <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      rr_q     <= rr_d;
      for (int i = 0; i < PORT_WIDTH; i++) pend_code_q[i] <= pend_code_d[i];
    end
  end

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_id_q[i]   <= '0;
        mem_code_q[i] <= '0;
      end
    end else begin
      if (push_w) begin
        mem_id_q[wr_ptr_q]   <= req_idx_w;
        mem_code_q[wr_ptr_q] <= pend_code_q[req_idx_w];
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_w && !pop_w) begin
        cnt_q <= cnt_q + LW'(1);
      end else if (!push_w && pop_w) begin
        cnt_q <= cnt_q - LW'(1);
      end
    end
  end

  // The head is read straight from storage; a write never targets the live head
  assign evt_valid  = (cnt_q != '0);
  assign evt_id     = mem_id_q[rd_ptr_q];
  assign evt_code   = mem_code_q[rd_ptr_q];
  assign evt_ovf    = ovf_q;
  assign fifo_level = cnt_q;

endmodule
`default_nettype wire
